// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the ALU multi-cycle divide path.
// Fixed latency: the result is valid with the complete pulse WIDTH+1 cycles after start.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_en,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             flush,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic             complete
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             start;
   logic             last;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] raw_x;
   logic             sign_q;
   logic             sign_r;
   logic             div0;

   logic [WIDTH-1:0] x_mag;
   logic [WIDTH-1:0] y_mag;
   logic [WIDTH:0]   rem_sh;
   logic             borrow;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] s_fix;
   logic [WIDTH-1:0] r_fix;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and control strobes; flush always wins
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      last     = 1'b0;
      if (flush) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (div_en) begin
                  state_nx = BUSY;
                  start    = 1'b1;
               end
            end
            BUSY: begin
               if (cnt == CW'(WIDTH - 1)) begin
                  state_nx = DONE;
                  last     = 1'b1;
               end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   assign complete = (state == DONE);

   // Operand magnitudes and one restoring step with the final sign fixup
   always_comb begin
      x_mag  = (div_signed && x[WIDTH-1]) ? -x : x;
      y_mag  = (div_signed && y[WIDTH-1]) ? -y : y;
      rem_sh = {rem, quo[WIDTH-1]};
      borrow = rem_sh < {1'b0, dvs};
      diff   = rem_sh[WIDTH-1:0] - dvs;
      rem_nx = borrow ? rem_sh[WIDTH-1:0] : diff;
      quo_nx = {quo[WIDTH-2:0], ~borrow};
      s_fix  = sign_q ? -quo_nx : quo_nx;
      r_fix  = sign_r ? -rem_nx : rem_nx;
      if (div0) begin
         s_fix = '1;
         r_fix = raw_x;
      end
   end

   // Operand capture, iteration state and registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         raw_x  <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         div0   <= 1'b0;
         s      <= '0;
         r      <= '0;
      end else if (!flush) begin
         if (start) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= x_mag;
            dvs    <= y_mag;
            raw_x  <= x;
            sign_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            sign_r <= div_signed & x[WIDTH-1];
            div0   <= (y == '0);
         end else if (state == BUSY) begin
            cnt <= cnt + CW'(1);
            rem <= rem_nx;
            quo <= quo_nx;
            if (last) begin
               s <= s_fix;
               r <= r_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Cycle 0 is the cycle in which a request is first driven.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        div_en;
   logic        div_signed;
   logic [31:0] x;
   logic [31:0] y;
   logic        flush;
   logic [31:0] s;
   logic [31:0] r;
   logic        complete;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] last_s;
   logic [31:0] last_r;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .div_en     (div_en),
      .div_signed (div_signed),
      .x          (x),
      .y          (y),
      .flush      (flush),
      .s          (s),
      .r          (r),
      .complete   (complete)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One request held until complete, then released; checks latency and results
   task automatic run_op(input string tag, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] es, input logic [31:0] er);
      int first;
      int pulses;
      logic [31:0] cs;
      logic [31:0] cr;
      first  = -1;
      pulses = 0;
      cs     = '0;
      cr     = '0;
      @(posedge clk); #1;
      div_en     = 1'b1;
      div_signed = sg;
      x          = a;
      y          = b;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         if (complete) begin
            pulses++;
            if (first < 0) begin
               first = c;
               cs    = s;
               cr    = r;
            end
         end
         @(posedge clk); #1;
         if (first >= 0) div_en = 1'b0;
      end
      check({tag, "_lat"}, 32'(first), 32'd33);
      check({tag, "_pulses"}, 32'(pulses), 32'd1);
      check({tag, "_s"}, cs, es);
      check({tag, "_r"}, cr, er);
      last_s = cs;
      last_r = cr;
   endtask

   initial begin
      int first;
      int second;
      int pulses;
      logic [31:0] cs;
      logic [31:0] cr;

      reset      = 1'b1;
      div_en     = 1'b0;
      div_signed = 1'b0;
      x          = '0;
      y          = '0;
      flush      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_s", s, 32'h0);
      check("rst_r", r, 32'h0);
      check("rst_complete", {31'b0, complete}, 32'h0);

      run_op("u7_2",     1'b0, 32'd7,        32'd2,        32'h3,        32'h1);
      run_op("sneg7_2",  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
      run_op("s7_neg2",  1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1);
      run_op("sneg_neg", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF);
      run_op("u_big16",  1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF);
      run_op("u_ff_ff",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0);
      run_op("u_wide",   1'b0, 32'hFFFFFFFF, 32'h80000001, 32'h1,        32'h7FFFFFFE);
      run_op("u_small",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
      run_op("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
      run_op("s_div0",   1'b1, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678);
      run_op("u_div0",   1'b0, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678);
      run_op("sn_div0",  1'b1, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFF9);

      // Flush mid-operation, then a new request at cycle 12
      first  = -1;
      pulses = 0;
      cs     = '0;
      cr     = '0;
      @(posedge clk); #1;
      div_en     = 1'b1;
      div_signed = 1'b0;
      x          = 32'd1000;
      y          = 32'd3;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (complete) begin
            pulses++;
            if (first < 0) begin
               first = c;
               cs    = s;
               cr    = r;
            end
         end
         if (c == 11) begin
            check("flush_hold_s", s, last_s);
            check("flush_hold_r", r, last_r);
         end
         @(posedge clk); #1;
         if (c + 1 == 10) flush = 1'b1;
         if (c + 1 == 11) begin
            flush  = 1'b0;
            div_en = 1'b0;
         end
         if (c + 1 == 12) begin
            div_en = 1'b1;
            x      = 32'd100;
            y      = 32'd7;
         end
         if (first >= 0) div_en = 1'b0;
      end
      check("flush_lat", 32'(first), 32'd45);
      check("flush_pulses", 32'(pulses), 32'd1);
      check("flush_s", cs, 32'd14);
      check("flush_r", cr, 32'd2);

      // flush together with div_en in IDLE must not start
      pulses = 0;
      @(posedge clk); #1;
      div_en = 1'b1;
      flush  = 1'b1;
      x      = 32'd9;
      y      = 32'd4;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (complete) pulses++;
         @(posedge clk); #1;
         div_en = 1'b0;
         flush  = 1'b0;
      end
      check("flush_start_pulses", 32'(pulses), 32'd0);

      // Back-to-back: div_en held through complete, next pair after it
      first  = -1;
      second = -1;
      pulses = 0;
      cs     = '0;
      cr     = '0;
      @(posedge clk); #1;
      div_en     = 1'b1;
      div_signed = 1'b0;
      x          = 32'd7;
      y          = 32'd2;
      for (int c = 0; c < 75; c++) begin
         @(negedge clk);
         if (complete) begin
            pulses++;
            if (pulses == 1) begin
               first = c;
               check("b2b_a_s", s, 32'h3);
               check("b2b_a_r", r, 32'h1);
            end else if (pulses == 2) begin
               second = c;
               cs     = s;
               cr     = r;
            end
         end
         @(posedge clk); #1;
         if (pulses == 1 && first == c) begin
            div_signed = 1'b1;
            x          = 32'hFFFFFF9C;
            y          = 32'd7;
         end
         if (pulses >= 2) div_en = 1'b0;
      end
      check("b2b_first", 32'(first), 32'd33);
      check("b2b_gap", 32'(second - first), 32'd34);
      check("b2b_pulses", 32'(pulses), 32'd2);
      check("b2b_b_s", cs, 32'hFFFFFFF2);
      check("b2b_b_r", cr, 32'hFFFFFFFE);

      // Reset in the middle of an operation
      pulses = 0;
      @(posedge clk); #1;
      div_en     = 1'b1;
      div_signed = 1'b0;
      x          = 32'd1000;
      y          = 32'd3;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (complete) pulses++;
         if (c == 21) begin
            check("rst_mid_s", s, 32'h0);
            check("rst_mid_r", r, 32'h0);
         end
         @(posedge clk); #1;
         if (c + 1 == 20) begin
            reset  = 1'b1;
            div_en = 1'b0;
         end
         if (c + 1 == 21) reset = 1'b0;
      end
      check("rst_mid_pulses", 32'(pulses), 32'd0);
      run_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider. It is the responder on the ALU's multi-cycle divide handshake.
- The ALU raises div_en for div/divu/mod/modu and waits for complete.
- The divider returns quotient and remainder together. The ALU selects s for div/divu and r for mod/modu.
- One quotient bit is produced per cycle. Latency is fixed and independent of operand values.

Parameters:
- WIDTH, 32, operand/result width in bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- div_en  input  1  request; held high with operands stable until complete
- div_signed  input  1  1 = signed (div/mod), 0 = unsigned (divu/modu); sampled at start
- x  input  WIDTH  dividend; sampled at start
- y  input  WIDTH  divisor; sampled at start
- flush  input  1  cancel in-flight op (exception/branch flush)
- s  output  WIDTH  quotient; registered
- r  output  WIDTH  remainder; registered
- complete  output  1  one-cycle pulse; s/r valid in that cycle

Behaviour:
- Reset values: state IDLE, complete=0, s=0, r=0, counter=0. Reset mid-operation aborts the operation with no complete pulse.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If div_en=1 and flush=0 in cycle N, capture the following and go to BUSY:
    - |x| and |y| (magnitudes only when div_signed=1)
    - sign_q = x[MSB]^y[MSB] (signed only)
    - sign_r = x[MSB] (signed only)
    - div0 = (y==0)
    - the raw x
  - Clear the partial remainder and the counter.
- BUSY:
  - Cycles N+1..N+WIDTH each perform one restoring step:
    - shift {rem, quo} left one bit, bringing in the next dividend MSB
    - trial = rem − |y|
    - if there is no borrow, rem = trial and quotient bit = 1; otherwise quotient bit = 0
  - Counter increments each step. On the step with counter==WIDTH−1, the final s/r are computed and registered, and the state goes to DONE.
- Final fixup, registered on the last step:
  - Signed: s = sign_q ? −quo : quo; r = sign_r ? −rem : rem. The remainder takes the sign of the dividend.
  - Unsigned: s = quo, r = rem.
  - div0 overrides regardless of sign: s = all ones, r = raw x.
  - Signed overflow (x = most-negative, y = −1): s = most-negative, r = 0. This falls out of two's-complement wrap; no special case is needed.
- DONE:
  - complete=1 for exactly one cycle, N+WIDTH+1 (cycle 33 after start for WIDTH=32).
  - The next state is IDLE unconditionally.
- Back-to-back requests:
  - The requester advances on complete.
  - If div_en is still high in the IDLE cycle after DONE, a new operation starts with the operands present then.
  - Minimum issue spacing is WIDTH+2 cycles.
- s/r hold their last values outside DONE. Consumers must qualify them with complete.
- flush:
  - In any state, flush=1 forces IDLE next cycle, complete=0, and no result update. s/r keep their old values.
  - flush has priority over div_en in IDLE (no start that cycle).
  - flush in DONE suppresses nothing already emitted: complete is combinationally the DONE state, and flush only affects the next state.
- div_en dropping while BUSY is illegal protocol. The divider ignores it and completes normally.
- No X propagation: every register has a defined reset value.

Test Plan:
- Unsigned 7 ÷ 2: div_en=1, div_signed=0, x=7, y=2 at cycle 0 -> complete only at cycle 33; s=0x00000003, r=0x00000001. complete=0 in cycles 0–32 and 34.
- Signed signs: x=0xFFFFFFF9 (−7), y=2 -> s=0xFFFFFFFD, r=0xFFFFFFFF. x=7, y=0xFFFFFFFE -> s=0xFFFFFFFD, r=0x00000001. Unsigned x=0xFFFFFFFF, y=0x10 -> s=0x0FFFFFFF, r=0x0000000F.
- Boundaries: signed 0x80000000 ÷ 0xFFFFFFFF -> s=0x80000000, r=0. Divide by zero, signed and unsigned, x=0x12345678, y=0 -> s=0xFFFFFFFF, r=0x12345678, both at cycle 33.
- Flush: start at cycle 0, flush=1 at cycle 10 -> no complete pulse, state IDLE at 11. New op x=100, y=7 at cycle 12 -> complete at 45, s=14, r=2. Also: flush and div_en together in IDLE -> no start.
- Back-to-back: div_en held high through complete with a new operand pair presented the cycle after complete -> second complete 34 cycles after the first, with correct results. Exactly one pulse per operation.
- Reset mid-op: reset=1 at cycle 20 -> s=0, r=0, complete stays 0. A fresh op after reset release completes with the normal 33-cycle latency.
